// File: rtl/apb_ucpd_pkg.sv
// UCPD receive shared definitions: K-codes, ordered-set patterns, sop type, event and state encodings.
// Ordered sets are packed with the first symbol in bits [4:0], matching the receive window.
package apb_ucpd_pkg;

   localparam logic [4:0] K_SYNC1 = 5'b11000;
   localparam logic [4:0] K_SYNC2 = 5'b10001;
   localparam logic [4:0] K_SYNC3 = 5'b00110;
   localparam logic [4:0] K_RST1  = 5'b00111;
   localparam logic [4:0] K_RST2  = 5'b11001;
   localparam logic [4:0] K_EOP   = 5'b01101;

   typedef enum logic [2:0] {
      SOP_T_SOP  = 3'd0,
      SOP_T_SOP1 = 3'd1,
      SOP_T_SOP2 = 3'd2,
      SOP_T_HRST = 3'd3,
      SOP_T_CRST = 3'd4
   } sop_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_SOP  = 2'd2,
      ST_DATA = 2'd3
   } rx_state_e;

   typedef struct packed {
      logic pre;
      logic sop;
      logic hrst;
      logic crst;
      logic byte_vld;
      logic eop;
      logic err;
   } rx_evt_t;

   function automatic logic [19:0] os_pattern(input sop_type_e t);
      case (t)
         SOP_T_SOP:  os_pattern = {K_SYNC2, K_SYNC1, K_SYNC1, K_SYNC1};
         SOP_T_SOP1: os_pattern = {K_SYNC3, K_SYNC3, K_SYNC1, K_SYNC1};
         SOP_T_SOP2: os_pattern = {K_SYNC3, K_SYNC1, K_SYNC3, K_SYNC1};
         SOP_T_HRST: os_pattern = {K_RST2,  K_RST1,  K_RST1,  K_RST1};
         default:    os_pattern = {K_SYNC3, K_RST1,  K_SYNC1, K_RST1};
      endcase
   endfunction

   // Tie-break order when several sets qualify: HRST, CRST, SOP, SOP', SOP''.
   function automatic sop_type_e os_prio(input int idx);
      case (idx)
         0:       os_prio = SOP_T_HRST;
         1:       os_prio = SOP_T_CRST;
         2:       os_prio = SOP_T_SOP;
         3:       os_prio = SOP_T_SOP1;
         default: os_prio = SOP_T_SOP2;
      endcase
   endfunction

   function automatic logic [2:0] os_hits(input logic [19:0] w, input logic [19:0] os);
      logic [2:0] n;
      n = 3'd0;
      for (int k = 0; k < 4; k++) begin
         if (w[5*k +: 5] == os[5*k +: 5]) n = n + 3'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/apb_ucpd_rx_sym_if.sv
// Bit-stream input and status/byte output bundle of the UCPD receive symbol engine.
interface apb_ucpd_rx_sym_if;
   logic       ucpden;
   logic       rx_en;
   logic       rx_bit;
   logic       rx_bit_vld;
   logic       rx_pre_cmplt;
   logic       rx_sop_cmplt;
   logic [2:0] rx_sop_type;
   logic       hrst_vld;
   logic       crst_vld;
   logic [7:0] rx_byte;
   logic       rx_byte_vld;
   logic [9:0] rx_byte_cnt;
   logic       eop_ok;
   logic       rx_err;

   modport master (
      output ucpden, rx_en, rx_bit, rx_bit_vld,
      input  rx_pre_cmplt, rx_sop_cmplt, rx_sop_type, hrst_vld, crst_vld,
             rx_byte, rx_byte_vld, rx_byte_cnt, eop_ok, rx_err
   );

   modport slave (
      input  ucpden, rx_en, rx_bit, rx_bit_vld,
      output rx_pre_cmplt, rx_sop_cmplt, rx_sop_type, hrst_vld, crst_vld,
             rx_byte, rx_byte_vld, rx_byte_cnt, eop_ok, rx_err
   );
endinterface

// File: rtl/apb_ucpd_dec5b4b.sv
// Combinational 5b->4b symbol decoder; zero latency, no backpressure.
// Symbols are given bit4..bit0 with bit0 received first.
module apb_ucpd_dec5b4b (
   input  logic [4:0] sym,
   output logic [3:0] data,
   output logic       is_data,
   output logic       is_eop,
   output logic       is_kcode
);
   import apb_ucpd_pkg::*;

   always_comb begin
      data    = 4'h0;
      is_data = 1'b1;
      case (sym)
         5'b11110: data = 4'h0;
         5'b01001: data = 4'h1;
         5'b10100: data = 4'h2;
         5'b10101: data = 4'h3;
         5'b01010: data = 4'h4;
         5'b01011: data = 4'h5;
         5'b01110: data = 4'h6;
         5'b01111: data = 4'h7;
         5'b10010: data = 4'h8;
         5'b10011: data = 4'h9;
         5'b10110: data = 4'hA;
         5'b10111: data = 4'hB;
         5'b11010: data = 4'hC;
         5'b11011: data = 4'hD;
         5'b11100: data = 4'hE;
         5'b11101: data = 4'hF;
         default:  is_data = 1'b0;
      endcase
      is_eop   = (sym == K_EOP);
      is_kcode = (sym == K_SYNC1) || (sym == K_SYNC2) || (sym == K_SYNC3) ||
                 (sym == K_RST1)  || (sym == K_RST2)  || is_eop;
   end
endmodule

// File: rtl/apb_ucpd_rx_sym.sv
// UCPD receive symbol engine: preamble, ordered-set match, 4b5b bytes, EOP; registered pulses 1 cycle after the completing bit, advances only on rx_bit_vld.
// Define UCPD_SOP_3OF4_EN to accept ordered sets with 3 of 4 K-codes matching.
module apb_ucpd_rx_sym #(
   parameter int PRE_MIN   = 20,
   parameter int SOP_TMO   = 96,
   parameter int MAX_BYTES = 264
) (
   input logic              ic_clk,
   input logic              ic_rst,
   apb_ucpd_rx_sym_if.slave rx
);
   import apb_ucpd_pkg::*;

`ifdef UCPD_SOP_3OF4_EN
   localparam logic [2:0] OS_MIN_HITS = 3'd3;
`else
   localparam logic [2:0] OS_MIN_HITS = 3'd4;
`endif

   rx_state_e  state_q, state_d;
   logic [19:0] win_q, win_d, win_nxt;
   logic [6:0]  cnt_q, cnt_d, cnt_inc, alt;
   logic [7:0]  byte_q, byte_d;
   logic [9:0]  bcnt_q, bcnt_d;
   sop_type_e   type_q, type_d, os_type;
   rx_evt_t     evt_q, evt_d;
   logic        os_hit;
   logic [2:0]  hits, best;

   logic [3:0] lo_dat, hi_dat;
   logic       lo_is_data, lo_is_eop, lo_is_kcode;
   logic       hi_is_data, hi_is_eop, hi_is_kcode;
   logic       unused_dec;

   assign win_nxt = {rx.rx_bit, win_q[19:1]};
   assign cnt_inc = cnt_q + 7'd1;
   assign alt     = ((cnt_q != 7'd0) && (rx.rx_bit != win_q[19])) ? cnt_inc : 7'd1;

   // At the 5th data bit the newest-symbol slot (hi decoder) holds the lo symbol.
   apb_ucpd_dec5b4b u_dec_lo (
      .sym(win_nxt[14:10]), .data(lo_dat), .is_data(lo_is_data),
      .is_eop(lo_is_eop), .is_kcode(lo_is_kcode)
   );
   apb_ucpd_dec5b4b u_dec_hi (
      .sym(win_nxt[19:15]), .data(hi_dat), .is_data(hi_is_data),
      .is_eop(hi_is_eop), .is_kcode(hi_is_kcode)
   );
   assign unused_dec = lo_is_eop ^ lo_is_kcode ^ hi_is_kcode;

   always_comb begin
      os_hit  = 1'b0;
      os_type = SOP_T_SOP;
      best    = 3'd0;
      hits    = 3'd0;
      for (int i = 0; i < 5; i++) begin
         hits = os_hits(win_nxt, os_pattern(os_prio(i)));
         if ((hits >= OS_MIN_HITS) && (hits > best)) begin
            best    = hits;
            os_hit  = 1'b1;
            os_type = os_prio(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      byte_d  = byte_q;
      bcnt_d  = bcnt_q;
      type_d  = type_q;
      evt_d   = '0;
      if (!rx.ucpden || !rx.rx_en) begin
         state_d = ST_IDLE;
         win_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_PRE;
               win_d   = '0;
               cnt_d   = '0;
               bcnt_d  = '0;
            end
            ST_PRE: if (rx.rx_bit_vld) begin
               win_d = win_nxt;
               if (alt == 7'(PRE_MIN)) begin
                  evt_d.pre = 1'b1;
                  state_d   = ST_SOP;
                  cnt_d     = '0;
               end else begin
                  cnt_d = alt;
               end
            end
            ST_SOP: if (rx.rx_bit_vld) begin
               win_d = win_nxt;
               if (os_hit) begin
                  type_d = os_type;
                  if (os_type == SOP_T_HRST) begin
                     evt_d.hrst = 1'b1;
                     state_d    = ST_IDLE;
                  end else if (os_type == SOP_T_CRST) begin
                     evt_d.crst = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     evt_d.sop = 1'b1;
                     state_d   = ST_DATA;
                     cnt_d     = '0;
                  end
               end else if (cnt_inc == 7'(SOP_TMO)) begin
                  evt_d.err = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            ST_DATA: if (rx.rx_bit_vld) begin
               win_d = win_nxt;
               cnt_d = cnt_inc;
               if (cnt_q == 7'd4) begin
                  if (hi_is_eop) begin
                     evt_d.eop = 1'b1;
                     state_d   = ST_IDLE;
                  end else if (!hi_is_data) begin
                     evt_d.err = 1'b1;
                     state_d   = ST_IDLE;
                  end
               end else if (cnt_q == 7'd9) begin
                  cnt_d = '0;
                  if (!hi_is_data || !lo_is_data || (bcnt_q == 10'(MAX_BYTES))) begin
                     evt_d.err = 1'b1;
                     state_d   = ST_IDLE;
                  end else begin
                     byte_d         = {hi_dat, lo_dat};
                     bcnt_d         = bcnt_q + 10'd1;
                     evt_d.byte_vld = 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge ic_clk or posedge ic_rst) begin
      if (ic_rst) begin
         state_q <= ST_IDLE;
         win_q   <= '0;
         cnt_q   <= '0;
         byte_q  <= '0;
         bcnt_q  <= '0;
         type_q  <= SOP_T_SOP;
         evt_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cnt_q   <= cnt_d;
         byte_q  <= byte_d;
         bcnt_q  <= bcnt_d;
         type_q  <= type_d;
         evt_q   <= evt_d;
      end
   end

   assign rx.rx_pre_cmplt = evt_q.pre;
   assign rx.rx_sop_cmplt = evt_q.sop;
   assign rx.hrst_vld     = evt_q.hrst;
   assign rx.crst_vld     = evt_q.crst;
   assign rx.rx_byte_vld  = evt_q.byte_vld;
   assign rx.eop_ok       = evt_q.eop;
   assign rx.rx_err       = evt_q.err;
   assign rx.rx_sop_type  = type_q;
   assign rx.rx_byte      = byte_q;
   assign rx.rx_byte_cnt  = bcnt_q;
endmodule

// File: tb/tb_apb_ucpd_rx_sym.sv
// Directed bench for apb_ucpd_rx_sym: hand-computed symbol streams with pulse counting monitor.
module tb_apb_ucpd_rx_sym;
   localparam logic [4:0] S1  = 5'b11000;
   localparam logic [4:0] S2  = 5'b10001;
   localparam logic [4:0] S3  = 5'b00110;
   localparam logic [4:0] R1  = 5'b00111;
   localparam logic [4:0] R2  = 5'b11001;
   localparam logic [4:0] EOP = 5'b01101;

   logic ic_clk = 1'b0;
   logic ic_rst;
   int   n_vec = 0;
   int   n_bad = 0;
   int   n_pre = 0, n_sop = 0, n_hrst = 0, n_bvld = 0, n_eop = 0, n_err = 0;
   int   b_pre, b_sop, b_hrst, b_bvld, b_eop, b_err;

   apb_ucpd_rx_sym_if rx ();
   apb_ucpd_rx_sym dut (.ic_clk(ic_clk), .ic_rst(ic_rst), .rx(rx));

   always #5 ic_clk = ~ic_clk;

   always @(negedge ic_clk) begin
      if (rx.rx_pre_cmplt) n_pre++;
      if (rx.rx_sop_cmplt) n_sop++;
      if (rx.hrst_vld)     n_hrst++;
      if (rx.rx_byte_vld)  n_bvld++;
      if (rx.eop_ok)       n_eop++;
      if (rx.rx_err)       n_err++;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] evts();
      return {rx.rx_pre_cmplt, rx.rx_sop_cmplt, rx.hrst_vld, rx.crst_vld,
              rx.rx_byte_vld, rx.eop_ok, rx.rx_err};
   endfunction

   task automatic snap();
      b_pre = n_pre; b_sop = n_sop; b_hrst = n_hrst;
      b_bvld = n_bvld; b_eop = n_eop; b_err = n_err;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge ic_clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      rx.rx_bit     = b;
      rx.rx_bit_vld = 1'b1;
      @(posedge ic_clk);
      #1;
      rx.rx_bit_vld = 1'b0;
   endtask

   task automatic send_sym(input logic [4:0] s);
      for (int i = 0; i < 5; i++) send_bit(s[i]);
   endtask

   task automatic send_pre(input int n);
      for (int i = 0; i < n; i++) send_bit(1'(i % 2));
   endtask

   task automatic start_pkt();
      rx.rx_en = 1'b0;
      idle(2);
      rx.rx_en = 1'b1;
      idle(2);
      snap();
   endtask

   initial begin
      ic_rst = 1'b1;
      rx.ucpden = 1'b0; rx.rx_en = 1'b0; rx.rx_bit = 1'b0; rx.rx_bit_vld = 1'b0;
      idle(3);
      chk("rst_evt_in_reset", 32'(evts()), 32'd0);
      ic_rst = 1'b0;
      idle(1);
      chk("rst_evt", 32'(evts()), 32'd0);
      chk("rst_type", 32'(rx.rx_sop_type), 32'd0);
      chk("rst_byte", 32'(rx.rx_byte), 32'd0);
      chk("rst_cnt", 32'(rx.rx_byte_cnt), 32'd0);

      // ucpden low keeps the engine idle
      rx.rx_en = 1'b1;
      idle(2);
      snap();
      send_pre(30);
      idle(2);
      chk("dis_no_pre", 32'(n_pre - b_pre), 32'd0);
      rx.ucpden = 1'b1;

      // 64-bit preamble, SOP, 0xA1 0x42, EOP
      start_pkt();
      send_pre(19);
      chk("t1_pre_early", 32'(n_pre - b_pre), 32'd0);
      send_bit(1'b1);
      chk("t1_pre_at20", 32'(rx.rx_pre_cmplt), 32'd1);
      for (int i = 20; i < 64; i++) send_bit(1'(i % 2));
      send_sym(S1); send_sym(S1); send_sym(S1); send_sym(S2);
      chk("t1_sop", 32'(rx.rx_sop_cmplt), 32'd1);
      chk("t1_type", 32'(rx.rx_sop_type), 32'd0);
      send_sym(5'b01001); send_sym(5'b10110);
      chk("t1_b0_vld", 32'(rx.rx_byte_vld), 32'd1);
      chk("t1_b0_dat", 32'(rx.rx_byte), 32'hA1);
      send_sym(5'b10100); send_sym(5'b01010);
      chk("t1_b1_dat", 32'(rx.rx_byte), 32'h42);
      send_sym(EOP);
      chk("t1_eop", 32'(rx.eop_ok), 32'd1);
      chk("t1_cnt", 32'(rx.rx_byte_cnt), 32'd2);
      idle(2);
      chk("t1_npre", 32'(n_pre - b_pre), 32'd1);
      chk("t1_nbvld", 32'(n_bvld - b_bvld), 32'd2);
      chk("t1_nerr", 32'(n_err - b_err), 32'd0);

      // Hard Reset ordered set, then a fresh preamble qualifies again
      start_pkt();
      send_pre(20);
      send_sym(R1); send_sym(R1); send_sym(R1); send_sym(R2);
      chk("t2_hrst", 32'(rx.hrst_vld), 32'd1);
      chk("t2_type", 32'(rx.rx_sop_type), 32'd3);
      idle(2);
      chk("t2_nhrst", 32'(n_hrst - b_hrst), 32'd1);
      chk("t2_nsop", 32'(n_sop - b_sop), 32'd0);
      send_pre(20);
      chk("t2_repre", 32'(rx.rx_pre_cmplt), 32'd1);
      chk("t2_nbvld", 32'(n_bvld - b_bvld), 32'd0);

      // SOP'' then a byte with an invalid hi symbol
      start_pkt();
      send_pre(20);
      send_sym(S1); send_sym(S3); send_sym(S1); send_sym(S3);
      chk("t3_sop", 32'(rx.rx_sop_cmplt), 32'd1);
      chk("t3_type", 32'(rx.rx_sop_type), 32'd2);
      send_sym(5'b11110); send_sym(5'b00000);
      chk("t3_err", 32'(rx.rx_err), 32'd1);
      chk("t3_vld", 32'(rx.rx_byte_vld), 32'd0);
      idle(2);
      chk("t3_nerr", 32'(n_err - b_err), 32'd1);
      chk("t3_nbvld", 32'(n_bvld - b_bvld), 32'd0);

      // Enable dropped on the bit that completes a SOP: no pulse, type kept
      start_pkt();
      send_pre(20);
      send_sym(S1); send_sym(S1); send_sym(S1);
      for (int i = 0; i < 4; i++) send_bit(S2[i]);
      rx.rx_bit = S2[4]; rx.rx_bit_vld = 1'b1; rx.rx_en = 1'b0;
      @(posedge ic_clk); #1;
      rx.rx_bit_vld = 1'b0;
      chk("t7_no_sop", 32'(rx.rx_sop_cmplt), 32'd0);
      idle(2);
      chk("t7_nsop", 32'(n_sop - b_sop), 32'd0);
      chk("t7_type", 32'(rx.rx_sop_type), 32'd2);

      // SOP search timeout on constant ones
      start_pkt();
      send_pre(20);
      for (int i = 0; i < 95; i++) send_bit(1'b1);
      chk("t4_err_early", 32'(n_err - b_err), 32'd0);
      send_bit(1'b1);
      chk("t4_err_at96", 32'(rx.rx_err), 32'd1);

      // Three bytes then enable dropped
      start_pkt();
      send_pre(20);
      send_sym(S1); send_sym(S1); send_sym(S1); send_sym(S2);
      send_sym(5'b11101); send_sym(5'b01011);
      chk("t5_b0_dat", 32'(rx.rx_byte), 32'h5F);
      send_sym(5'b11110); send_sym(5'b01001);
      send_sym(5'b10101); send_sym(5'b11010);
      chk("t5_b2_dat", 32'(rx.rx_byte), 32'hC3);
      rx.rx_en = 1'b0;
      idle(4);
      chk("t5_cnt", 32'(rx.rx_byte_cnt), 32'd3);
      chk("t5_neop", 32'(n_eop - b_eop), 32'd0);
      chk("t5_nerr", 32'(n_err - b_err), 32'd0);
      rx.rx_en = 1'b1;
      idle(2);
      chk("t5_cnt_clr", 32'(rx.rx_byte_cnt), 32'd0);

      // S1 S1 S3 S2: one K-code off from SOP
      start_pkt();
      send_pre(20);
      send_sym(S1); send_sym(S1); send_sym(S3); send_sym(S2);
`ifdef UCPD_SOP_3OF4_EN
      chk("t6_sop", 32'(rx.rx_sop_cmplt), 32'd1);
      chk("t6_type", 32'(rx.rx_sop_type), 32'd0);
`else
      chk("t6_no_sop", 32'(rx.rx_sop_cmplt), 32'd0);
      send_pre(75);
      chk("t6_err_early", 32'(n_err - b_err), 32'd0);
      send_bit(1'b1);
      chk("t6_err_tmo", 32'(rx.rx_err), 32'd1);
`endif

      // Overrun: 264 bytes accepted, the 265th raises rx_err
      start_pkt();
      send_pre(20);
      send_sym(S1); send_sym(S1); send_sym(S1); send_sym(S2);
      for (int i = 0; i < 264; i++) begin
         send_sym(5'b11110); send_sym(5'b11110);
      end
      idle(1);
      chk("t8_cnt", 32'(rx.rx_byte_cnt), 32'd264);
      chk("t8_nbvld", 32'(n_bvld - b_bvld), 32'd264);
      send_sym(5'b11110); send_sym(5'b11110);
      chk("t8_err", 32'(rx.rx_err), 32'd1);
      chk("t8_vld", 32'(rx.rx_byte_vld), 32'd0);
      chk("t8_cnt_hold", 32'(rx.rx_byte_cnt), 32'd264);

      // Asynchronous reset mid-packet
      start_pkt();
      send_pre(20);
      send_sym(S1); send_sym(S1); send_sym(S3); send_sym(S3);
      send_sym(5'b01001); send_sym(5'b10110);
      chk("t9_type", 32'(rx.rx_sop_type), 32'd1);
      chk("t9_cnt", 32'(rx.rx_byte_cnt), 32'd1);
      #2;
      ic_rst = 1'b1;
      #1;
      chk("t9_rst_cnt", 32'(rx.rx_byte_cnt), 32'd0);
      chk("t9_rst_type", 32'(rx.rx_sop_type), 32'd0);
      chk("t9_rst_byte", 32'(rx.rx_byte), 32'd0);
      idle(2);
      ic_rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
